uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Runtime-configurable UART transmitter. It is the next generation of the SoC's fixed 8N1 transmitter and adds:
- 5..MAX_DATA_BITS data bits
- optional even/odd parity
- 1 or 2 stop bits
- a valid/ready handshake and a frame-done pulse

It sits in the UART peripheral between the register/FIFO interface and the serial pin, and is timed by the shared baud-tick generator (sck_rising_edge).

Parameters:
OVERSAMPLE, 16, number of sck_rising_edge pulses per serial bit; must be a power of two from 4 to 64.
MAX_DATA_BITS, 8, width of tx_data; maximum supported data length; range 5..9.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sck_rising_edge  input  1  one-clk baud tick, OVERSAMPLE ticks per bit
tx_data_valid  input  1  frame request
tx_data_ready  output  1  transmitter can accept a frame
tx_data  input  MAX_DATA_BITS  payload, sent LSB first
cfg_data_bits  input  4  data length; valid range 5..MAX_DATA_BITS
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop_bits  input  1  0 = one stop bit, 1 = two stop bits
sout  output  1  serial line, idle high
busy  output  1  frame in progress
tx_done  output  1  one-clk pulse after the final stop bit

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values: sout=1, busy=0, tx_done=0, tx_data_ready=1, state IDLE, all counters 0. Reset asserted mid-frame returns sout to 1 immediately (asynchronously). No partial frame resumes after reset.
- States: IDLE, START, DATA, PARITY, STOP.
- tx_data_ready = (state==IDLE). busy = !tx_data_ready.
- Accept: tx_data_valid && tx_data_ready in clk cycle N. At acceptance:
  - tx_data, cfg_data_bits, cfg_parity and cfg_stop_bits are snapshotted.
  - Config changes after acceptance have no effect until the next frame.
- Config clamping: cfg_data_bits below 5 is treated as 5; above MAX_DATA_BITS is treated as MAX_DATA_BITS.
- Start of frame: in cycle N+1, state=START and sout=0. The line output is registered; there is no combinational path from any input to sout.
- Bit timing: each bit lasts exactly OVERSAMPLE sck_rising_edge pulses. The edge counter increments only on a tick and wraps to 0 on the last tick of the bit.
- Bit advance: the next bit value appears on sout the clk after that last tick.
- Frame order:
  - START: one bit, 0.
  - DATA: cfg_data_bits bits, LSB first, shifted out of a buffer.
  - PARITY: present only when parity is enabled.
  - STOP: 1 or 2 bits, 1.
- Parity:
  - even mode: parity bit = XOR of the transmitted data bits only (bits above the length are masked).
  - odd mode: parity bit = inverted XOR.
  - Computed at acceptance.
- End of frame: on the last tick of the final stop bit, state goes to IDLE and tx_done=1 for exactly one clk.
  - tx_data_ready=1 in that same cycle, so back-to-back frames have only one clk of extra idle high.
- No ticks: if sck_rising_edge stays low, the FSM and sout hold indefinitely.
- Requests while busy: tx_data_valid asserted while busy is ignored (not accepted and not queued). The requester holds valid until it sees ready.
- Frame length in bits: 1 + data + (parity?1:0) + stop. Range 7..13.

Decomposition:
- uart_pkg (shared): parity_t enum {PAR_NONE, PAR_EVEN, PAR_ODD}, tx_state_t enum, constant MIN_DATA_BITS=5.
- Sub-module uart_bit_timer: tick counter with clear, parametrised by OVERSAMPLE, outputting bit_end. It will be reused by the next-generation receiver.

Test Plan:
- 8N1, tx_data=0xA5, tick every clk, OVERSAMPLE=16 -> sout = 0,1,0,1,0,0,1,0,1,1, each held 16 clks; tx_done 160 clks after START entry; ready low throughout.
- 7E1, tx_data=0x41 -> sout = 0, 1,0,0,0,0,0,1, parity 0, stop 1; 10 bits total.
- 5O2, tx_data=0xFF (bits 5..7 ignored) -> sout = 0, 1,1,1,1,1, parity 0, 1,1; 9 bits; tx_done after 144 ticks.
- cfg_data_bits=3 and cfg changed to 8N1 mid-frame -> frame sent as 5-bit with the original snapshot parity/stop; the later config is ignored.
- tx_data_valid held high across two frames with ticks every 4th clk -> second START begins exactly 1 clk after tx_done; a valid pulse during busy produces no frame.
- rst_n pulsed during DATA bit 3 -> sout=1 asynchronously, ready=1 after release, no tx_done; the next request produces a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmitter and the upcoming receiver.
// No logic of its own; latency not applicable.
// No flow control; pure type/constant definitions.
package uart_pkg;

    localparam int MIN_DATA_BITS = 5;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Register encoding 2'b11 is a second "no parity" code.
    function automatic parity_t decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'b01:   decode_parity = PAR_EVEN;
            2'b10:   decode_parity = PAR_ODD;
            default: decode_parity = PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Counts baud ticks within one serial bit and flags the last tick of the bit.
// o_bit_end is combinational on the tick of the final count; the counter wraps the same clk.
// No handshake; holds its count while no tick arrives, clear has priority over tick.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_bit_end
);

    localparam int            CW      = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LP_LAST = CW'(OVERSAMPLE - 1);

    logic [CW-1:0] r_cnt;

    assign o_bit_end = i_tick && !i_clear && (r_cnt == LP_LAST);

    // Tick counter: advances only on a tick, wraps to zero on the bit's last tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            r_cnt <= o_bit_end ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..MAX_DATA_BITS data, none/even/odd parity, 1/2 stop.
// Start bit drives sout the clk after acceptance; each bit lasts OVERSAMPLE baud ticks.
// Accepts a frame only in IDLE (ready); requests while busy are dropped, not queued.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE    = 16,
    parameter int MAX_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sck_rising_edge,
    input  logic                     tx_data_valid,
    output logic                     tx_data_ready,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    input  logic [3:0]               cfg_data_bits,
    input  logic [1:0]               cfg_parity,
    input  logic                     cfg_stop_bits,
    output logic                     sout,
    output logic                     busy,
    output logic                     tx_done
);

    localparam logic [3:0] LP_MIN_BITS = 4'(MIN_DATA_BITS);
    localparam logic [3:0] LP_MAX_BITS = 4'(MAX_DATA_BITS);

    tx_state_t                r_state;
    tx_state_t                w_state_nxt;
    logic                     r_sout;
    logic                     w_sout_nxt;
    logic                     r_done;
    logic                     w_done_nxt;

    // Per-frame snapshot of payload and configuration.
    logic [MAX_DATA_BITS-1:0] r_shift;
    logic [3:0]               r_bits_left;
    logic                     r_par_en;
    logic                     r_par_bit;
    logic                     r_stop_left;

    logic                     w_accept;
    logic                     w_load;
    logic                     w_shift;
    logic                     w_bits_dec;
    logic                     w_stop_dec;
    logic                     w_bit_end;
    logic                     w_timer_clr;
    logic [3:0]               w_nbits;
    logic [MAX_DATA_BITS-1:0] w_mask;
    logic                     w_par_xor;
    parity_t                  w_parity;

    assign tx_data_ready = (r_state == ST_IDLE);
    assign busy          = !tx_data_ready;
    assign sout          = r_sout;
    assign tx_done       = r_done;
    assign w_accept      = tx_data_valid && tx_data_ready;
    assign w_timer_clr   = (r_state == ST_IDLE);
    assign w_parity      = decode_parity(cfg_parity);

    uart_bit_timer #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_timer_clr),
        .i_tick    (sck_rising_edge),
        .o_bit_end (w_bit_end)
    );

    // Clamp the requested length and compute parity over only the bits that will be sent.
    always_comb begin
        w_nbits = cfg_data_bits;
        w_mask  = '0;
        if (cfg_data_bits < LP_MIN_BITS) begin
            w_nbits = LP_MIN_BITS;
        end else if (cfg_data_bits > LP_MAX_BITS) begin
            w_nbits = LP_MAX_BITS;
        end
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            w_mask[i] = (i < int'(w_nbits));
        end
        w_par_xor = ^(tx_data & w_mask);
    end

    // Next-state and next-line-value logic; sout is registered from w_sout_nxt.
    always_comb begin
        w_state_nxt = r_state;
        w_sout_nxt  = r_sout;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_bits_dec  = 1'b0;
        w_stop_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_sout_nxt = 1'b1;
                if (w_accept) begin
                    w_state_nxt = ST_START;
                    w_sout_nxt  = 1'b0;
                    w_load      = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_sout_nxt  = r_shift[0];
                    w_shift     = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bits_left != 4'd0) begin
                        w_sout_nxt = r_shift[0];
                        w_shift    = 1'b1;
                        w_bits_dec = 1'b1;
                    end else if (r_par_en) begin
                        w_state_nxt = ST_PARITY;
                        w_sout_nxt  = r_par_bit;
                    end else begin
                        w_state_nxt = ST_STOP;
                        w_sout_nxt  = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_sout_nxt  = 1'b1;
                end
            end
            ST_STOP: begin
                w_sout_nxt = 1'b1;
                if (w_bit_end) begin
                    if (r_stop_left) begin
                        w_stop_dec = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sout_nxt  = 1'b1;
            end
        endcase
    end

    // FSM state, registered line output and done pulse; reset forces the line idle high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sout  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sout  <= w_sout_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Snapshot on acceptance, then shift data out LSB first and count remaining bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift     <= '0;
            r_bits_left <= '0;
            r_par_en    <= 1'b0;
            r_par_bit   <= 1'b0;
            r_stop_left <= 1'b0;
        end else if (w_load) begin
            r_shift     <= tx_data;
            r_bits_left <= w_nbits - 4'd1;
            r_par_en    <= (w_parity != PAR_NONE);
            r_par_bit   <= (w_parity == PAR_ODD) ? ~w_par_xor : w_par_xor;
            r_stop_left <= cfg_stop_bits;
        end else begin
            if (w_shift) begin
                r_shift <= r_shift >> 1;
            end
            if (w_bits_dec) begin
                r_bits_left <= r_bits_left - 4'd1;
            end
            if (w_stop_dec) begin
                r_stop_left <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table of hand-computed frames plus directed corner sequences.
// Frames are checked bit by bit against expected serial sequences, counting baud ticks per bit.
// Covers config snapshot, back-to-back frames, ignored requests, tick stalls and mid-frame reset.
module tb_uart_tx_cfg;

    localparam int OS  = 16;
    localparam int MDB = 8;

    logic           clk             = 1'b0;
    logic           rst_n           = 1'b1;
    logic           sck_rising_edge = 1'b0;
    logic           tx_data_valid   = 1'b0;
    logic           tx_data_ready;
    logic [MDB-1:0] tx_data         = '0;
    logic [3:0]     cfg_data_bits   = 4'd8;
    logic [1:0]     cfg_parity      = 2'b00;
    logic           cfg_stop_bits   = 1'b0;
    logic           sout;
    logic           busy;
    logic           tx_done;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_div = 1;
    int phase    = 0;

    // Expected frame: seq holds the serial bits in send order, first bit at position len-1.
    typedef struct {
        logic [7:0]  data;
        logic [3:0]  nb;
        logic [1:0]  par;
        logic        st;
        logic [12:0] seq;
        int          len;
    } vec_t;

    vec_t vecs[8];

    uart_tx_cfg #(
        .OVERSAMPLE    (OS),
        .MAX_DATA_BITS (MDB)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sck_rising_edge (sck_rising_edge),
        .tx_data_valid   (tx_data_valid),
        .tx_data_ready   (tx_data_ready),
        .tx_data         (tx_data),
        .cfg_data_bits   (cfg_data_bits),
        .cfg_parity      (cfg_parity),
        .cfg_stop_bits   (cfg_stop_bits),
        .sout            (sout),
        .busy            (busy),
        .tx_done         (tx_done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Baud tick every tick_div clks; tick_div of 0 stops ticks entirely.
    always @(posedge clk) begin
        #1;
        if (tick_div <= 0) begin
            phase           = 0;
            sck_rising_edge = 1'b0;
        end else begin
            if (phase >= tick_div - 1) phase = 0;
            else                       phase = phase + 1;
            sck_rising_edge = (phase == 0);
        end
    end

    task automatic chk(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Present a request and wait until it is accepted (returns in the accept cycle).
    task automatic start_frame(input logic [7:0] d, input logic [3:0] nb,
                               input logic [1:0] par, input logic st);
        int guard;
        guard = 0;
        @(negedge clk);
        tx_data       = d;
        cfg_data_bits = nb;
        cfg_parity    = par;
        cfg_stop_bits = st;
        tx_data_valid = 1'b1;
        while (tx_data_ready !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("accept", tx_data_ready === 1'b1, int'(tx_data_ready), 1);
    endtask

    // Follow a frame from START entry; each bit must hold for exactly OS ticks.
    task automatic check_frame(input string name, input logic [12:0] seq, input int len,
                               input int exp_clks, input bit keep_valid);
        int          clks;
        int          ticks;
        int          guard;
        logic [12:0] tmp;
        logic [3:0]  want;
        logic [3:0]  got;
        logic [3:0]  bad;
        bit          ok;
        clks = 0;
        for (int k = 0; k < len; k++) begin
            tmp   = seq >> (len - 1 - k);
            want  = {1'b0, 1'b1, 1'b0, tmp[0]};
            ok    = 1'b1;
            bad   = '0;
            ticks = 0;
            guard = 0;
            while (ticks < OS && guard < 1000) begin
                @(negedge clk);
                if (k == 0 && guard == 0 && !keep_valid) tx_data_valid = 1'b0;
                got = {tx_done, busy, tx_data_ready, sout};
                if (got !== want && ok) begin
                    ok  = 1'b0;
                    bad = got;
                end
                if (sck_rising_edge) ticks++;
                guard++;
                clks++;
            end
            chk($sformatf("%s bit%0d {done,busy,rdy,sout}", name, k),
                ok && (ticks == OS), int'(bad), int'(want));
        end
        @(negedge clk);
        chk($sformatf("%s done {done,rdy,sout}", name),
            {tx_done, tx_data_ready, sout} === 3'b111,
            int'({tx_done, tx_data_ready, sout}), 7);
        if (exp_clks != 0) chk($sformatf("%s clks", name), clks == exp_clks, clks, exp_clks);
    endtask

    // Line must stay idle with no frame and no done pulse.
    task automatic idle_check(input string name, input int cycles);
        bit         ok;
        logic [3:0] bad;
        ok  = 1'b1;
        bad = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if ({tx_done, busy, tx_data_ready, sout} !== 4'b0011 && ok) begin
                ok  = 1'b0;
                bad = {tx_done, busy, tx_data_ready, sout};
            end
        end
        chk($sformatf("%s {done,busy,rdy,sout}", name), ok, int'(bad), 3);
    endtask

    // Main sequence.
    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset sout",  sout === 1'b1,          int'(sout),          1);
        chk("reset busy",  busy === 1'b0,          int'(busy),          0);
        chk("reset ready", tx_data_ready === 1'b1, int'(tx_data_ready), 1);
        chk("reset done",  tx_done === 1'b0,       int'(tx_done),       0);
        rst_n = 1'b1;

        //           data   bits  par    stop  serial sequence (send order)   len
        vecs[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, 13'b0101001011,                10}; // 8N1
        vecs[1] = '{8'h41, 4'd7,  2'b01, 1'b0, 13'b0100000101,                10}; // 7E1
        vecs[2] = '{8'hFF, 4'd5,  2'b10, 1'b1, 13'b011111011,                  9}; // 5O2
        vecs[3] = '{8'h2C, 4'd6,  2'b01, 1'b1, 13'b0001101111,                10}; // 6E2
        vecs[4] = '{8'h00, 4'd8,  2'b10, 1'b0, 13'b00000000011,               11}; // 8O1
        vecs[5] = '{8'h1A, 4'd3,  2'b00, 1'b0, 13'b0010111,                    7}; // 3 -> 5N1
        vecs[6] = '{8'h3C, 4'd15, 2'b11, 1'b0, 13'b0001111001,                10}; // 15 -> 8, par 11 = none
        vecs[7] = '{8'h80, 4'd8,  2'b01, 1'b1, 13'b000000001111,              12}; // 8E2

        tick_div = 1;
        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].data, vecs[i].nb, vecs[i].par, vecs[i].st);
            check_frame($sformatf("vec%0d", i), vecs[i].seq, vecs[i].len, vecs[i].len * OS, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d done one clk", i), tx_done === 1'b0 && tx_data_ready === 1'b1,
                int'(tx_done), 0);
        end

        // Config and data changed right after acceptance: frame keeps the 5O2 snapshot.
        start_frame(8'h1A, 4'd3, 2'b10, 1'b1);
        @(posedge clk);
        #2;
        cfg_data_bits = 4'd8;
        cfg_parity    = 2'b00;
        cfg_stop_bits = 1'b0;
        tx_data       = 8'hFF;
        check_frame("snap", 13'b001011011, 9, 9 * OS, 1'b0);

        // Valid held across two frames, tick every 4th clk: second START right after done.
        tick_div = 4;
        start_frame(8'hA5, 4'd8, 2'b00, 1'b0);
        @(posedge clk);
        #2 tx_data = 8'h0F;
        check_frame("b2b first", 13'b0101001011, 10, 0, 1'b1);
        check_frame("b2b second", 13'b0111100001, 10, 0, 1'b0);
        idle_check("b2b after", 20);
        tick_div = 1;

        // A one-clk request mid-frame is dropped.
        start_frame(8'h13, 4'd5, 2'b00, 1'b0);
        fork
            check_frame("busyreq", 13'b0110011, 7, 7 * OS, 1'b0);
            begin
                repeat (30) @(negedge clk);
                tx_data_valid = 1'b1;
                @(negedge clk);
                tx_data_valid = 1'b0;
            end
        join
        idle_check("busyreq idle", 40);

        // Ticks stop mid-frame for 200 clks: line and FSM must hold, frame completes intact.
        start_frame(8'h00, 4'd8, 2'b10, 1'b0);
        fork
            check_frame("stall", 13'b00000000011, 11, 0, 1'b0);
            begin
                repeat (40) @(negedge clk);
                tick_div = 0;
                repeat (200) @(negedge clk);
                tick_div = 1;
            end
        join
        idle_check("stall idle", 5);

        // Reset during data bit 3 of 0xA5 (bit value 0).
        start_frame(8'hA5, 4'd8, 2'b00, 1'b0);
        @(negedge clk);
        tx_data_valid = 1'b0;
        repeat (68) @(negedge clk);
        chk("rst pre sout", sout === 1'b0, int'(sout), 0);
        chk("rst pre busy", busy === 1'b1, int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async sout",  sout === 1'b1,          int'(sout),          1);
        chk("rst async ready", tx_data_ready === 1'b1, int'(tx_data_ready), 1);
        chk("rst async busy",  busy === 1'b0,          int'(busy),          0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check("rst idle", 40);
        start_frame(8'h41, 4'd7, 2'b01, 1'b0);
        check_frame("rst next", 13'b0100000101, 10, 10 * OS, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
